// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory byte-stream loader.
package imem_pkg;

    localparam int PKG_MEM_BYTES = 32;
    localparam int MAX_WORDS     = PKG_MEM_BYTES / 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_LEN  = 2'b01;
    localparam logic [1:0] ERR_CSUM = 2'b10;

endpackage

// File: rtl/imem_loader.sv
// Loads a length-prefixed, XOR-checksummed byte stream into instruction memory
// and holds the core in reset until a load finishes cleanly.
//
// state   | meaning
// IDLE    | after reset, waiting for start
// LEN     | waiting for the word-count byte
// DATA    | writing payload bytes to consecutive addresses
// CSUM    | waiting for the checksum byte
// DONE    | load succeeded, core released
// ERR     | bad length or checksum, core held in reset
module imem_loader
    import imem_pkg::*;
#(
    parameter int MEM_BYTES = imem_pkg::PKG_MEM_BYTES,
    parameter int ADDR_W    = $clog2(MEM_BYTES)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              core_reset,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err_code
);

    localparam int WORDS_MAX = MEM_BYTES / 4;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W:0]   cnt;
    logic [ADDR_W:0]   cnt_inc;
    logic [ADDR_W:0]   total;
    logic [7:0]        acc;
    logic              accept;
    logic              len_bad;
    logic              csum_ok;

    assign accept  = rx_valid && rx_ready;
    assign cnt_inc = cnt + {{ADDR_W{1'b0}}, 1'b1};
    assign len_bad = (rx_data == 8'd0) || (int'(rx_data) > WORDS_MAX);
    assign csum_ok = (rx_data == acc);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        rx_ready   = 1'b0;
        busy       = 1'b0;
        core_reset = 1'b1;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                core_reset = (state != ST_DONE);
                if (start) begin
                    state_nxt = ST_LEN;
                end
            end
            ST_LEN: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (accept) begin
                    state_nxt = len_bad ? ST_ERR : ST_DATA;
                end
            end
            ST_DATA: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (accept && (cnt_inc == total)) begin
                    state_nxt = ST_CSUM;
                end
            end
            ST_CSUM: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (accept) begin
                    state_nxt = csum_ok ? ST_DONE : ST_ERR;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath: counter, running XOR, registered write port and sticky status.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            total     <= '0;
            acc       <= 8'd0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 8'd0;
            done      <= 1'b0;
            err_code  <= ERR_NONE;
        end else begin
            mem_we <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        cnt      <= '0;
                        acc      <= 8'd0;
                        done     <= 1'b0;
                        err_code <= ERR_NONE;
                    end
                end
                ST_LEN: begin
                    if (accept) begin
                        if (len_bad) begin
                            err_code <= ERR_LEN;
                        end else begin
                            // 4*N; the upper bits of N are zero once the range check passes
                            total <= {rx_data[ADDR_W-2:0], 2'b00};
                        end
                    end
                end
                ST_DATA: begin
                    if (accept) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= cnt[ADDR_W-1:0];
                        mem_wdata <= rx_data;
                        acc       <= acc ^ rx_data;
                        cnt       <= cnt_inc;
                    end
                end
                ST_CSUM: begin
                    if (accept) begin
                        if (csum_ok) begin
                            done <= 1'b1;
                        end else begin
                            err_code <= ERR_CSUM;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as bytes are accepted.
module tb_imem_loader;
    import imem_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       start = 1'b0;
    logic [7:0] rx_data = 8'd0;
    logic       rx_valid = 1'b0;
    logic       rx_ready;
    logic       mem_we;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       core_reset;
    logic       busy;
    logic       done;
    logic [1:0] err_code;

    imem_loader #(.MEM_BYTES(32), .ADDR_W(5)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .core_reset (core_reset),
        .busy       (busy),
        .done       (done),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int addr;
        int data;
    } wr_t;

    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  wr_count = 0;
    wr_t sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    wr_t got;
    always @(negedge clk) begin
        if (reset_n && mem_we === 1'b1) begin
            wr_count++;
            if (sb.size() == 0) begin
                check_val("unexpected_write", 32'd1, 32'd0);
            end else begin
                got = sb.pop_front();
                check_val("wr_addr", 32'(mem_addr), 32'(got.addr));
                check_val("wr_data", 32'(mem_wdata), 32'(got.data));
                check_val("wr_cycle", 32'(cyc), 32'(got.cyc));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Ends on a negedge, one cycle after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input bit pay, input int addr,
                             input int gap_max, input bit inj);
        int gap;
        int to;
        gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        if (inj && gap == 0) gap = 1;
        for (int g = 0; g < gap; g++) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            start    = inj && (g == 0);
            @(negedge clk);
        end
        start    = 1'b0;
        rx_data  = b;
        rx_valid = 1'b1;
        to = 0;
        while (rx_ready !== 1'b1 && to < 50) begin
            @(negedge clk);
            to++;
        end
        if (to >= 50) begin
            check_val("ready_timeout", 32'd0, 32'd1);
            rx_valid = 1'b0;
            return;
        end
        if (pay) sb.push_back('{cyc + 1, addr, int'(b)});
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_stream(input logic [7:0] s[$], input int gap_max, input bit inj);
        for (int i = 0; i < s.size(); i++) begin
            bit pay;
            pay = (i > 0) && (i < s.size() - 1);
            send_byte(s[i], pay, i - 1, gap_max, inj && pay);
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_val("start_ready", 32'(rx_ready), 32'd1);
        check_val("start_busy", 32'(busy), 32'd1);
        check_val("start_done_clr", 32'(done), 32'd0);
        check_val("start_err_clr", 32'(err_code), 32'(ERR_NONE));
        check_val("start_core_rst", 32'(core_reset), 32'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_ready"}, 32'(rx_ready), 32'd0);
        check_val({tag, "_we"}, 32'(mem_we), 32'd0);
        check_val({tag, "_addr"}, 32'(mem_addr), 32'd0);
        check_val({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
        check_val({tag, "_core_rst"}, 32'(core_reset), 32'd1);
        check_val({tag, "_busy"}, 32'(busy), 32'd0);
        check_val({tag, "_done"}, 32'(done), 32'd0);
        check_val({tag, "_err"}, 32'(err_code), 32'(ERR_NONE));
    endtask

    task automatic check_end(input string tag, input bit exp_done, input logic [1:0] exp_err,
                             input int wr_before, input int exp_writes);
        check_val({tag, "_done"}, 32'(done), 32'(exp_done));
        check_val({tag, "_err"}, 32'(err_code), 32'(exp_err));
        check_val({tag, "_core_rst"}, 32'(core_reset), 32'(!exp_done));
        check_val({tag, "_busy"}, 32'(busy), 32'd0);
        check_val({tag, "_ready"}, 32'(rx_ready), 32'd0);
        check_val({tag, "_writes"}, 32'(wr_count - wr_before), 32'(exp_writes));
        check_val({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    endtask

    logic [7:0]  str_a[$];
    logic [7:0]  str_bad[$];
    logic [7:0]  str_prog[$];
    logic [7:0]  one[$];
    logic [31:0] prog[8];
    logic [7:0]  x;
    int          wb;

    initial begin
        str_a   = '{8'h01, 8'h33, 8'h03, 8'h94, 8'h00, 8'hA4};
        str_bad = '{8'h01, 8'h33, 8'h03, 8'h94, 8'h00, 8'hA5};
        prog = '{32'h00100093, 32'h00200113, 32'h002081b3, 32'h40208233,
                 32'h0020f2b3, 32'h0020e333, 32'h0020c3b3, 32'h00000073};
        str_prog.push_back(8'h08);
        x = 8'h00;
        for (int w = 0; w < 8; w++) begin
            for (int k = 0; k < 4; k++) begin
                str_prog.push_back(prog[w][8*k +: 8]);
                x = x ^ prog[w][8*k +: 8];
            end
        end
        str_prog.push_back(x);

        #2 reset_n = 1'b0;
        #1 check_reset_vals("rst");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_reset_vals("idle");

        // Single instruction, back-to-back bytes
        do_start();
        wb = wr_count;
        send_stream(str_a, 0, 1'b0);
        check_end("one_word", 1'b1, ERR_NONE, wb, 4);

        // Full memory
        do_start();
        wb = wr_count;
        send_stream(str_prog, 0, 1'b0);
        check_end("full", 1'b1, ERR_NONE, wb, 32);

        // Zero length
        do_start();
        wb = wr_count;
        one = '{8'h00};
        send_stream(one, 0, 1'b0);
        repeat (2) @(negedge clk);
        check_end("len0", 1'b0, ERR_LEN, wb, 0);

        // Length one beyond capacity
        do_start();
        wb = wr_count;
        one = '{8'(MAX_WORDS + 1)};
        send_stream(one, 0, 1'b0);
        repeat (2) @(negedge clk);
        check_end("len9", 1'b0, ERR_LEN, wb, 0);

        // Wrong checksum
        do_start();
        wb = wr_count;
        send_stream(str_bad, 0, 1'b0);
        check_end("bad_csum", 1'b0, ERR_CSUM, wb, 4);

        // Random gaps with start pulses during the payload
        do_start();
        wb = wr_count;
        send_stream(str_prog, 3, 1'b1);
        check_end("gaps", 1'b1, ERR_NONE, wb, 32);

        // Asynchronous reset after two payload bytes
        do_start();
        send_byte(8'h01, 1'b0, 0, 0, 1'b0);
        send_byte(8'h33, 1'b1, 0, 0, 1'b0);
        send_byte(8'h03, 1'b1, 1, 0, 1'b0);
        #2 reset_n = 1'b0;
        #1 check_reset_vals("mid_rst");
        sb.delete();
        @(negedge clk);
        reset_n = 1'b1;
        do_start();
        wb = wr_count;
        send_stream(str_a, 0, 1'b0);
        check_end("after_rst", 1'b1, ERR_NONE, wb, 4);

        repeat (3) @(negedge clk);
        check_val("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
